// File: rtl/position_cache_nb_scheduler_pkg.sv
// Shared types, slot-offset table and elaboration-time neighbour/wrap helpers
// for the neighbour-position distributor.
package position_cache_nb_scheduler_pkg;

    localparam int POS_W          = 16;
    localparam int NUM_SLOTS_HALF = 14;
    localparam int NUM_SLOTS_FULL = 27;
    localparam int X_DIM_DEF      = 3;
    localparam int Y_DIM_DEF      = 3;
    localparam int Z_DIM_DEF      = 3;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [POS_W-1:0] z;
    } offset_tuple_t;

    typedef struct packed {
        logic signed [1:0] x;
        logic signed [1:0] y;
        logic signed [1:0] z;
    } wrap_tuple_t;

    // Half-shell offsets {dx,dy,dz}, 2-bit two's complement; full-shell slots 14..26 negate 1..13.
    localparam logic [0:13][5:0] SLOT_OFS = {
        6'b00_00_00, 6'b01_00_00, 6'b11_01_00, 6'b00_01_00, 6'b01_01_00,
        6'b11_11_01, 6'b00_11_01, 6'b01_11_01, 6'b11_00_01, 6'b00_00_01,
        6'b01_00_01, 6'b11_01_01, 6'b00_01_01, 6'b01_01_01
    };

    function automatic int num_slots(input int mode);
        return (mode != 0) ? NUM_SLOTS_FULL : NUM_SLOTS_HALF;
    endfunction

    function automatic int slot_delta(input int s, input int axis);
        int                m;
        logic [5:0]        e;
        logic signed [1:0] v;
        m = (s >= NUM_SLOTS_HALF) ? s - (NUM_SLOTS_HALF - 1) : s;
        e = SLOT_OFS[m];
        case (axis)
            0:       v = e[5:4];
            1:       v = e[3:2];
            default: v = e[1:0];
        endcase
        return (s >= NUM_SLOTS_HALF) ? -int'(v) : int'(v);
    endfunction

    function automatic int wrap_mod(input int c, input int dim);
        return (c < 0) ? c + dim : ((c >= dim) ? c - dim : c);
    endfunction

    function automatic int nb_cell_index(input int h, input int s, input int mode,
                                         input int nx, input int ny, input int nz);
        int x, y, z, r;
        x = h % nx;
        y = (h / nx) % ny;
        z = h / (nx * ny);
        if (s < num_slots(mode)) begin
            r = wrap_mod(z + slot_delta(s, 2), nz) * nx * ny
              + wrap_mod(y + slot_delta(s, 1), ny) * nx
              + wrap_mod(x + slot_delta(s, 0), nx);
        end else begin
            r = 0;
        end
        return r;
    endfunction

    function automatic logic signed [1:0] axis_wrap(input int c, input int dim);
        return (c == dim) ? 2'sb01 : ((c == -1) ? 2'sb11 : 2'sb00);
    endfunction

    function automatic wrap_tuple_t nb_wrap(input int h, input int s, input int mode,
                                            input int nx, input int ny, input int nz);
        wrap_tuple_t w;
        w = '0;
        if (s < num_slots(mode)) begin
            w.x = axis_wrap(h % nx + slot_delta(s, 0), nx);
            w.y = axis_wrap((h / nx) % ny + slot_delta(s, 1), ny);
            w.z = axis_wrap(h / (nx * ny) + slot_delta(s, 2), nz);
        end else begin
            w = '0;
        end
        return w;
    endfunction

endpackage

// File: rtl/position_cache_nb_scheduler_if.sv
// Handshake and data bundle between the position caches, the scheduler and the PE array.
interface position_cache_nb_scheduler_if
    import position_cache_nb_scheduler_pkg::*;
#(
    parameter int NUM_CELLS = 27,
    parameter int P         = 4
) ();
    logic                                   start;
    logic                                   in_valid;
    offset_tuple_t [NUM_CELLS-1:0]          rd_nb_position;
    logic                                   out_ready;
    logic                                   out_valid;
    offset_tuple_t [NUM_CELLS-1:0][P-1:0]   out_position;
    wrap_tuple_t   [NUM_CELLS-1:0][P-1:0]   out_wrap;
    logic [P-1:0]                           out_slot_valid;
    logic [P-1:0][4:0]                      out_slot;
    logic                                   out_last;
    logic                                   busy;
    logic                                   done;

    modport master (
        output start, in_valid, rd_nb_position, out_ready,
        input  out_valid, out_position, out_wrap, out_slot_valid, out_slot, out_last, busy, done
    );

    modport slave (
        input  start, in_valid, rd_nb_position, out_ready,
        output out_valid, out_position, out_wrap, out_slot_valid, out_slot, out_last, busy, done
    );
endinterface

// File: rtl/position_cache_nb_scheduler_nb_slot_select.sv
// Combinational per-(cell, port) mux: picks the neighbour cache readout and wrap
// tag for the slot this port carries in group g, from tables built at elaboration.
module nb_slot_select
    import position_cache_nb_scheduler_pkg::*;
#(
    parameter int CELL       = 0,
    parameter int PORT       = 0,
    parameter int P          = 4,
    parameter int G          = 4,
    parameter int GW         = 2,
    parameter int SHELL_MODE = 0,
    parameter int X_DIM      = 3,
    parameter int Y_DIM      = 3,
    parameter int Z_DIM      = 3,
    parameter int NUM_CELLS  = 27
) (
    input  logic [GW-1:0]                  g_i,
    input  offset_tuple_t [NUM_CELLS-1:0]  rd_nb_position_i,
    output offset_tuple_t                  position_o,
    output wrap_tuple_t                    wrap_o
);
    localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int WW = $bits(wrap_tuple_t);

    function automatic logic [G*CW-1:0] build_idx();
        logic [G*CW-1:0] t;
        t = '0;
        for (int gi = 0; gi < G; gi++)
            t[gi*CW +: CW] = CW'(nb_cell_index(CELL, gi*P + PORT, SHELL_MODE, X_DIM, Y_DIM, Z_DIM));
        return t;
    endfunction

    function automatic logic [G*WW-1:0] build_wrap();
        logic [G*WW-1:0] t;
        t = '0;
        for (int gi = 0; gi < G; gi++)
            t[gi*WW +: WW] = nb_wrap(CELL, gi*P + PORT, SHELL_MODE, X_DIM, Y_DIM, Z_DIM);
        return t;
    endfunction

    function automatic logic [G-1:0] build_vld();
        logic [G-1:0] t;
        t = '0;
        for (int gi = 0; gi < G; gi++)
            t[gi] = (gi*P + PORT) < num_slots(SHELL_MODE);
        return t;
    endfunction

    localparam logic [G-1:0][CW-1:0] IDX_TAB  = build_idx();
    localparam wrap_tuple_t [G-1:0]  WRAP_TAB = build_wrap();
    localparam logic [G-1:0]         VLD_TAB  = build_vld();

    // Slot mux; padding slots past the end of the sweep read as zero.
    always_comb begin
        position_o = '0;
        wrap_o     = '0;
        if ((int'(g_i) < G) && VLD_TAB[g_i]) begin
            position_o = rd_nb_position_i[IDX_TAB[g_i]];
            wrap_o     = WRAP_TAB[g_i];
        end else begin
            position_o = '0;
            wrap_o     = '0;
        end
    end
endmodule

// File: rtl/position_cache_nb_scheduler.sv
// Sweep FSM, group counter and output register that stream each cell's home and
// neighbour positions to the PE array, NUM_NB_PORTS slots per beat.
module position_cache_nb_scheduler
    import position_cache_nb_scheduler_pkg::*;
#(
    parameter int SHELL_MODE   = 0,
    parameter int NUM_NB_PORTS = 4,
    parameter int X_DIM        = X_DIM_DEF,
    parameter int Y_DIM        = Y_DIM_DEF,
    parameter int Z_DIM        = Z_DIM_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    position_cache_nb_scheduler_if.slave  bus
);
    localparam int NUM_SLOTS = num_slots(SHELL_MODE);
    localparam int P         = NUM_NB_PORTS;
    localparam int NUM_CELLS = X_DIM * Y_DIM * Z_DIM;
    localparam int G         = (NUM_SLOTS + P - 1) / P;
    localparam int GW        = (G > 1) ? $clog2(G) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    logic [1:0]                           state_q, state_d;
    logic [GW-1:0]                        g_q, g_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 out_last_q, done_q, done_d;
    offset_tuple_t [NUM_CELLS-1:0][P-1:0] out_position_q;
    wrap_tuple_t   [NUM_CELLS-1:0][P-1:0] out_wrap_q;
    logic [P-1:0]                         out_slot_valid_q, slot_vld_s;
    logic [P-1:0][4:0]                    out_slot_q, slot_num_s;
    offset_tuple_t                        sel_pos_s  [NUM_CELLS][P];
    wrap_tuple_t                          sel_wrap_s [NUM_CELLS][P];
    logic                                 capture_s, accept_last_s;
    int                                   slot_idx;

    assign capture_s     = (state_q == ST_RUN) && bus.in_valid && (!out_valid_q || bus.out_ready);
    assign accept_last_s = (state_q == ST_LAST) && out_valid_q && bus.out_ready;

    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
        for (genvar p = 0; p < P; p++) begin : g_port
            nb_slot_select #(
                .CELL(c), .PORT(p), .P(P), .G(G), .GW(GW), .SHELL_MODE(SHELL_MODE),
                .X_DIM(X_DIM), .Y_DIM(Y_DIM), .Z_DIM(Z_DIM), .NUM_CELLS(NUM_CELLS)
            ) u_sel (
                .g_i              (g_q),
                .rd_nb_position_i (bus.rd_nb_position),
                .position_o       (sel_pos_s[c][p]),
                .wrap_o           (sel_wrap_s[c][p])
            );
        end
    end

    // Slot number and validity carried on each port for the current group.
    always_comb begin
        slot_idx   = 0;
        slot_vld_s = '0;
        slot_num_s = '0;
        for (int p = 0; p < P; p++) begin
            slot_idx = int'(g_q) * P + p;
            if (slot_idx < NUM_SLOTS) begin
                slot_vld_s[p] = 1'b1;
                slot_num_s[p] = 5'(slot_idx);
            end else begin
                slot_vld_s[p] = 1'b0;
                slot_num_s[p] = 5'd0;
            end
        end
    end

    // Sweep FSM; a start coinciding with the done pulse is dropped.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !done_q) begin
                    state_d = ST_RUN;
                    g_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (capture_s && (g_q == GW'(G - 1))) begin
                    state_d = ST_LAST;
                end else if (capture_s) begin
                    g_d = g_q + GW'(1);
                end else begin
                    g_d = g_q;
                end
            end
            ST_LAST: begin
                if (accept_last_s) begin
                    state_d = ST_IDLE;
                    g_d     = '0;
                end else begin
                    state_d = ST_LAST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                g_d     = '0;
            end
        endcase
    end

    // Output valid: set on capture, cleared once the PE array takes the beat.
    always_comb begin
        done_d = accept_last_s;
        if (capture_s) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output register; beat data only moves on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            g_q              <= '0;
            out_valid_q      <= 1'b0;
            out_last_q       <= 1'b0;
            done_q           <= 1'b0;
            out_position_q   <= '0;
            out_wrap_q       <= '0;
            out_slot_valid_q <= '0;
            out_slot_q       <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            if (capture_s) begin
                out_last_q       <= (g_q == GW'(G - 1));
                out_slot_valid_q <= slot_vld_s;
                out_slot_q       <= slot_num_s;
                for (int c = 0; c < NUM_CELLS; c++) begin
                    for (int p = 0; p < P; p++) begin
                        out_position_q[c][p] <= sel_pos_s[c][p];
                        out_wrap_q[c][p]     <= sel_wrap_s[c][p];
                    end
                end
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_position   = out_position_q;
    assign bus.out_wrap       = out_wrap_q;
    assign bus.out_slot_valid = out_slot_valid_q;
    assign bus.out_slot       = out_slot_q;
    assign bus.out_last       = out_last_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = done_q;
endmodule
